// File: rtl/config_mem_pkg.sv
// rtl/config_mem_pkg.sv - config word layout, FSM states and helpers for config_mem_rw
package config_mem_pkg;

   localparam int DSIZE         = 16;
   localparam int AER_BIT_WIDTH = 32;

   localparam int SPIKE_AER_LSB  = 0;
   localparam int SPIKE_AER_MSB  = SPIKE_AER_LSB + AER_BIT_WIDTH - 1;
   localparam int RST_POT_LSB    = SPIKE_AER_MSB + 1;
   localparam int RST_POT_MSB    = RST_POT_LSB + DSIZE - 1;
   localparam int TH_MASK_LSB    = RST_POT_MSB + 1;
   localparam int TH_MASK_MSB    = TH_MASK_LSB + DSIZE - 1;
   localparam int RAND_TH_BIT    = TH_MASK_MSB + 1;
   localparam int NURN_TYPE_BIT  = RAND_TH_BIT + 1;
   localparam int CFG_WORD_WIDTH = NURN_TYPE_BIT + 1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } cfg_state_e;

   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/config_mem_rd_port.sv
// rtl/config_mem_rd_port.sv - one registered read port with range check and write-first bypass
module config_mem_rd_port
   import config_mem_pkg::*;
#(
   parameter int NUM_NURNS          = 256,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int WORD_WIDTH         = CFG_WORD_WIDTH
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          run_i,
   input  logic                          rd_en_i,
   input  logic [NURN_CNT_BIT_WIDTH-1:0] rd_addr_i,
   input  logic [WORD_WIDTH-1:0]         mem_word_i,
   input  logic                          wr_hit_i,
   input  logic [NURN_CNT_BIT_WIDTH-1:0] wr_addr_i,
   input  logic [WORD_WIDTH-1:0]         wr_word_i,
   output logic [WORD_WIDTH-1:0]         rd_data_o,
   output logic                          rd_vld_o
);

   logic                  accept;
   logic [WORD_WIDTH-1:0] next_word;

   assign accept = run_i & rd_en_i;

   // Out-of-range reads return zero; a same-address write this cycle wins over the array.
   always_comb begin
      next_word = '0;
      if (addr_in_range(32'(rd_addr_i), NUM_NURNS)) begin
         if (wr_hit_i && (wr_addr_i == rd_addr_i)) begin
            next_word = wr_word_i;
         end else begin
            next_word = mem_word_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_data_o <= '0;
         rd_vld_o  <= 1'b0;
      end else begin
         rd_vld_o <= accept;
         if (accept) begin
            rd_data_o <= next_word;
         end
      end
   end

endmodule

// File: rtl/config_mem_rw.sv
// rtl/config_mem_rw.sv - runtime-writable multi-read-port neuron config memory with clear sweep
module config_mem_rw
   import config_mem_pkg::*;
#(
   parameter int NUM_NURNS          = 256,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int WORD_WIDTH         = CFG_WORD_WIDTH,
   parameter int NUM_RD_PORTS       = 2,
   parameter int INIT_ON_RESET      = 1
) (
   input  logic                                       clk_i,
   input  logic                                       rst_n_i,
   input  logic                                       wrEn_i,
   input  logic [NURN_CNT_BIT_WIDTH-1:0]              wrAddr_i,
   input  logic [WORD_WIDTH-1:0]                      wrData_i,
   input  logic [WORD_WIDTH-1:0]                      wrMask_i,
   output logic                                       wrRdy_o,
   input  logic [NUM_RD_PORTS-1:0]                    rdEn_i,
   input  logic [NUM_RD_PORTS*NURN_CNT_BIT_WIDTH-1:0] rdAddr_i,
   output logic [NUM_RD_PORTS*WORD_WIDTH-1:0]         rdData_o,
   output logic [NUM_RD_PORTS-1:0]                    rdVld_o,
   output logic                                       initDone_o
);

   localparam int AW = NURN_CNT_BIT_WIDTH;
   localparam cfg_state_e RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

   cfg_state_e            state_q;
   cfg_state_e            state_d;
   logic [AW-1:0]         sweep_cnt_q;
   logic                  sweep_last;
   logic                  sweep_we;
   logic                  run_q;
   logic                  wr_hit;
   logic [WORD_WIDTH-1:0] wr_word;
   logic [WORD_WIDTH-1:0] mem [NUM_NURNS];

   // run_q is separate from state_q so the status outputs stay low while reset is held,
   // even when the FSM resets straight into RUN.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= RESET_STATE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == INIT) && sweep_last) begin
         state_d = RUN;
      end
   end

   always_comb begin
      sweep_we   = (state_q == INIT);
      initDone_o = run_q;
      wrRdy_o    = run_q;
   end

   assign sweep_last = (32'(sweep_cnt_q) == NUM_NURNS - 1);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sweep_cnt_q <= '0;
      end else if (sweep_we) begin
         sweep_cnt_q <= sweep_cnt_q + AW'(1);
      end
   end

   assign wr_hit  = rst_n_i & run_q & wrEn_i & addr_in_range(32'(wrAddr_i), NUM_NURNS);
   assign wr_word = (mem[wrAddr_i] & ~wrMask_i) | (wrData_i & wrMask_i);

   always_ff @(posedge clk_i) begin
      if (rst_n_i && sweep_we) begin
         mem[sweep_cnt_q] <= '0;
      end else if (wr_hit) begin
         mem[wrAddr_i] <= wr_word;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [AW-1:0]         rd_addr;
      logic [WORD_WIDTH-1:0] mem_word;

      assign rd_addr  = rdAddr_i[p*AW +: AW];
      assign mem_word = mem[rd_addr];

      config_mem_rd_port #(
         .NUM_NURNS          (NUM_NURNS),
         .NURN_CNT_BIT_WIDTH (NURN_CNT_BIT_WIDTH),
         .WORD_WIDTH         (WORD_WIDTH)
      ) u_rd_port (
         .clk_i      (clk_i),
         .rst_n_i    (rst_n_i),
         .run_i      (run_q),
         .rd_en_i    (rdEn_i[p]),
         .rd_addr_i  (rd_addr),
         .mem_word_i (mem_word),
         .wr_hit_i   (wr_hit),
         .wr_addr_i  (wrAddr_i),
         .wr_word_i  (wr_word),
         .rd_data_o  (rdData_o[p*WORD_WIDTH +: WORD_WIDTH]),
         .rd_vld_o   (rdVld_o[p])
      );
   end

endmodule

// File: doc/config_mem_rw.md
Name: config_mem_rw

Overview:
Runtime-writable, multi-read-port neuron configuration memory. It is the successor to the file-initialised read-only config store.
- Words are programmed over a masked write port, fed by the NoC config-packet decoder, so configuration can change without re-simulation.
- Reads are served to NUM_RD_PORTS independent consumers (controller, learning unit, etc.) with 1-cycle latency.
- After reset the block clears itself with a hardware sweep before accepting traffic.

Parameters:
NUM_NURNS, 256, number of config words (one per neuron); need not be a power of two
NURN_CNT_BIT_WIDTH, 8, address width; must satisfy 2^NURN_CNT_BIT_WIDTH >= NUM_NURNS
WORD_WIDTH, 66, config word width (default = 1+1+DSIZE+DSIZE+AER_BIT_WIDTH with DSIZE=16, AER=32)
NUM_RD_PORTS, 2, number of independent read ports (1..4)
INIT_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = no sweep, contents undefined until written

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
wrEn_i  in  1  write request
wrAddr_i  in  NURN_CNT_BIT_WIDTH  write address
wrData_i  in  WORD_WIDTH  write data
wrMask_i  in  WORD_WIDTH  per-bit write enable (1 = update the bit)
wrRdy_o  out  1  write accepted this cycle when wrEn_i=1
rdEn_i  in  NUM_RD_PORTS  per-port read enable
rdAddr_i  in  NUM_RD_PORTS*NURN_CNT_BIT_WIDTH  packed read addresses; port p occupies slice p
rdData_o  out  NUM_RD_PORTS*WORD_WIDTH  packed registered read data
rdVld_o  out  NUM_RD_PORTS  read data valid, one cycle after an accepted read
initDone_o  out  1  clear sweep complete; block operational

Behaviour:
- Reset: one clock, clk_i; reset is synchronous and active-low (rst_n_i). While rst_n_i=0 at a rising edge, all outputs and state are cleared: rdData_o=0, rdVld_o=0, wrRdy_o=0, initDone_o=0, sweep counter=0, FSM=INIT (or RUN if INIT_ON_RESET=0). Memory array contents are not reset.
- FSM states: INIT, RUN.
  - INIT: writes mem[cnt]=0 each cycle, cnt 0..NUM_NURNS-1. After writing NUM_NURNS-1, goes to RUN. The sweep takes exactly NUM_NURNS cycles after reset release.
  - RUN: terminal state until the next reset.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- initDone_o=1 and wrRdy_o=1 are registered in RUN; both go high on the edge entering RUN. With INIT_ON_RESET=0 they go high on the first edge after reset release.
- During INIT: wrEn_i and rdEn_i are ignored; rdVld_o stays 0 and no data is written.
- Write (RUN): when wrEn_i=1, mem[a] <= (mem[a] & ~wrMask_i) | (wrData_i & wrMask_i).
  - Takes effect in one cycle; there is no back-pressure in RUN.
  - wrMask_i=0 leaves the word unchanged.
- Read (RUN), per port p:
  - rdEn_i[p]=1 at edge N gives rdData_o[p] = word at edge N+1 and rdVld_o[p]=1 for exactly one cycle.
  - rdEn_i[p]=0 drops rdVld_o[p] to 0; rdData_o[p] holds its last value.
- Read/write collision (same address, same cycle): write-first bypass. rdData_o returns the merged post-write word. All ports colliding on that address see the same merged value.
- Multiple ports reading the same address in the same cycle: all serviced, no arbitration.
- Out-of-range address (>= NUM_NURNS):
  - Write: dropped; memory unchanged.
  - Read: rdData_o[p]=0 with rdVld_o[p]=1.
- No combinational path from any input to any output.

Decomposition:
- Package config_mem_pkg holds:
  - field widths and bit offsets of the config word: NURN_TYPE [65], RAND_TH [64], TH_MASK [63:48], RST_POT [47:32], SPIKE_AER [31:0];
  - derived WORD_WIDTH constant;
  - the FSM state enum {INIT, RUN}.
- Sub-module config_mem_rd_port: one read port. It does address range check, collision bypass merge and the output register, and is instantiated NUM_RD_PORTS times in a generate loop.
- Top level holds the array, write logic, sweep counter and FSM.

Test Plan:
1. Reset release (defaults) -> initDone_o/wrRdy_o rise exactly 256 cycles later. A read of addr 0x7F on both ports the next cycle -> rdData_o=0, rdVld_o=2'b11 one cycle later.
2. Write addr 0x05 with data 0x3_FFFF_FFFF_FFFF_FFFF and mask all-ones, then write data 0 with mask 0x0_0000_0000_FFFF_FFFF -> a read of 0x05 returns 0x3_FFFF_FFFF_0000_0000.
3. Same-cycle write addr 0x10 (data 0x1_2345, full mask) with port0 reading 0x10 and port1 reading 0x11 -> port0 data 0x1_2345, port1 data 0, both valid next cycle.
4. Reset pulsed at sweep cycle 100 -> initDone_o stays low and rises 256 cycles after the second release. Words written before that reset read back 0.
5. rdEn_i pulsed on port1 only for 1 cycle -> rdVld_o=2'b10 for exactly one cycle. rdData_o[port1] holds afterwards while rdVld_o=0.
6. NUM_NURNS=200: write to addr 0xC8 then read 0xC8 -> rdData_o=0 with rdVld_o=1. A read of addr 0xC7 is unaffected by the dropped write.
